// File: rtl/coord_disp_pkg.sv
// Shared constants, FSM encoding and input saturation for the coordinate BCD capture block.
package coord_disp_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int MAX_DISP   = 9999;
    localparam int BITCNT_W   = $clog2(BIN_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             ovf;
        logic [BIN_W-1:0] value;
    } sat_t;

    // Negative or too-large values clamp to the largest displayable number.
    function automatic sat_t saturate(input logic [31:0] v);
        sat_t r;
        if (v[31] || (v > 32'(MAX_DISP))) begin
            r.ovf   = 1'b1;
            r.value = BIN_W'(MAX_DISP);
        end else begin
            r.ovf   = 1'b0;
            r.value = v[BIN_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One combinational double-dabble step: add-3 correction per digit, then shift in one binary bit.
module bcd_dd_step
    import coord_disp_pkg::*;
(
    input  logic [BCD_W-1:0] scratch,
    input  logic             bit_in,
    output logic [BCD_W-1:0] scratch_next
);

    logic [BCD_W-1:0] adjusted;

    // Each digit is corrected independently; the +3 never exceeds 4 bits for digits 5..9.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            assign adjusted[gi*4 +: 4] = (scratch[gi*4 +: 4] >= 4'd5)
                                         ? scratch[gi*4 +: 4] + 4'd3
                                         : scratch[gi*4 +: 4];
        end
    endgenerate

    assign scratch_next = {adjusted[BCD_W-2:0], bit_in};

endmodule

// File: rtl/coord_bcd_capture.sv
// Periodically snapshots x/y coordinates, converts them to packed BCD and publishes both atomically.
module coord_bcd_capture
    import coord_disp_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1_000_000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      xCoord,
    input  logic [31:0]      yCoord,
    output logic [BCD_W-1:0] xBcd,
    output logic [BCD_W-1:0] yBcd,
    output logic             xOvf,
    output logic             yOvf,
    output logic             busy,
    output logic             updated
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);

    logic [CNT_W-1:0]    cnt_reg;
    logic                tick;
    state_t              state_reg;
    state_t              state_next;
    logic [BITCNT_W-1:0] bit_cnt_reg;
    logic [BIN_W-1:0]    x_bin_reg;
    logic [BIN_W-1:0]    y_bin_reg;
    logic [BCD_W-1:0]    x_scr_reg;
    logic [BCD_W-1:0]    y_scr_reg;
    logic [BCD_W-1:0]    x_scr_next;
    logic [BCD_W-1:0]    y_scr_next;
    logic                x_ovf_reg;
    logic                y_ovf_reg;
    sat_t                x_sat;
    sat_t                y_sat;

    assign tick  = (cnt_reg == CNT_W'(REFRESH_CYCLES - 1));
    assign x_sat = saturate(xCoord);
    assign y_sat = saturate(yCoord);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        updated    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tick) state_next = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (bit_cnt_reg == '0) state_next = DONE;
            end
            DONE: begin
                updated    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    bcd_dd_step u_x_step (
        .scratch      (x_scr_reg),
        .bit_in       (x_bin_reg[BIN_W-1]),
        .scratch_next (x_scr_next)
    );

    bcd_dd_step u_y_step (
        .scratch      (y_scr_reg),
        .bit_in       (y_bin_reg[BIN_W-1]),
        .scratch_next (y_scr_next)
    );

    // Outputs are written on the final shift edge so they are valid in the DONE cycle with updated.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bit_cnt_reg <= '0;
            x_bin_reg   <= '0;
            y_bin_reg   <= '0;
            x_scr_reg   <= '0;
            y_scr_reg   <= '0;
            x_ovf_reg   <= 1'b0;
            y_ovf_reg   <= 1'b0;
            xBcd        <= '0;
            yBcd        <= '0;
            xOvf        <= 1'b0;
            yOvf        <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    x_bin_reg   <= x_sat.value;
                    y_bin_reg   <= y_sat.value;
                    x_ovf_reg   <= x_sat.ovf;
                    y_ovf_reg   <= y_sat.ovf;
                    x_scr_reg   <= '0;
                    y_scr_reg   <= '0;
                    bit_cnt_reg <= BITCNT_W'(BIN_W - 1);
                end
                SHIFT: begin
                    x_scr_reg   <= x_scr_next;
                    y_scr_reg   <= y_scr_next;
                    x_bin_reg   <= {x_bin_reg[BIN_W-2:0], 1'b0};
                    y_bin_reg   <= {y_bin_reg[BIN_W-2:0], 1'b0};
                    bit_cnt_reg <= bit_cnt_reg - 1'b1;
                    if (bit_cnt_reg == '0) begin
                        xBcd <= x_scr_next;
                        yBcd <= y_scr_next;
                        xOvf <= x_ovf_reg;
                        yOvf <= y_ovf_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coord_bcd_capture.sv
// Randomized scoreboard bench: decimal reference model, queue of expected snapshots, negedge monitor.
module tb_coord_bcd_capture;

    localparam int RC = 20;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] xCoord = '0;
    logic [31:0] yCoord = '0;
    logic [15:0] xBcd;
    logic [15:0] yBcd;
    logic        xOvf;
    logic        yOvf;
    logic        busy;
    logic        updated;

    coord_bcd_capture #(.REFRESH_CYCLES(RC)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .xCoord  (xCoord),
        .yCoord  (yCoord),
        .xBcd    (xBcd),
        .yBcd    (yBcd),
        .xOvf    (xOvf),
        .yOvf    (yOvf),
        .busy    (busy),
        .updated (updated)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        xo;
        logic        yo;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_run = 0;
    logic mon_en = 1'b0;
    exp_t last_e = '0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: clamp, then peel decimal digits arithmetically.
    function automatic logic [16:0] ref_conv(input logic [31:0] v);
        int unsigned n;
        logic        ovf;
        if ($signed(v) < 0 || v > 32'd9999) begin
            n   = 9999;
            ovf = 1'b1;
        end else begin
            n   = v;
            ovf = 1'b0;
        end
        return {ovf, 4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y);
        logic [16:0] rx;
        logic [16:0] ry;
        exp_t e;
        xCoord = x;
        yCoord = y;
        rx = ref_conv(x);
        ry = ref_conv(y);
        e.x = rx[15:0];
        e.y = ry[15:0];
        e.xo = rx[16];
        e.yo = ry[16];
        exp_q.push_back(e);
        $display("[TB] drive x=%h y=%h -> expect x=%h/%0b y=%h/%0b", x, y, e.x, e.xo, e.y, e.yo);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return 32'd9999 - 32'($urandom_range(0, 3));
            2: return 32'd10000 + 32'($urandom_range(0, 3));
            default: return 32'($urandom_range(0, 9999));
        endcase
    endfunction

    always @(negedge Clk) begin
        if (mon_en && !Reset) begin
            if (updated) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_update: got pulse at cycle %0d required none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] update cyc=%0d x=%h/%0b y=%h/%0b", cyc, xBcd, xOvf, yBcd, yOvf);
                    check("xBcd", 32'(xBcd), 32'(e.x));
                    check("yBcd", 32'(yBcd), 32'(e.y));
                    check("xOvf", 32'(xOvf), 32'(e.xo));
                    check("yOvf", 32'(yOvf), 32'(e.yo));
                    check("update_phase", 32'(cyc % RC), 32'((2 * RC - 5) % RC));
                    check("busy_len", 32'(busy_run), 32'd15);
                    check("busy_at_update", 32'(busy), 32'd0);
                    last_e = e;
                end
                busy_run = 0;
            end else begin
                if (busy) busy_run++;
                check("hold_out", {xBcd, yBcd}, {last_e.x, last_e.y});
                check("hold_ovf", 32'({xOvf, yOvf}), 32'({last_e.xo, last_e.yo}));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [31:0] dir_x [10] = '{32'd1234, 32'd9999, 32'hFFFF_FFFF, 32'd42, 32'd7777,
                                32'd10000, 32'd0, 32'd0, 32'h8000_0000, 32'd4321};
    logic [31:0] dir_y [10] = '{32'd567, 32'd10000, 32'd0, 32'd5, 32'd1,
                                32'd9999, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'd8765};

    initial begin
        int nrand;
        nrand = 120;
        #1;
        check("rst_xBcd", 32'(xBcd), 32'd0);
        check("rst_yBcd", 32'(yBcd), 32'd0);
        check("rst_ovf", 32'({xOvf, yOvf}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_updated", 32'(updated), 32'd0);
        repeat (3) @(negedge Clk);

        // Each value is driven one cycle after the previous capture, i.e. during its SHIFT.
        Reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < nrand; i++) begin
            if (i == 0) drive(dir_x[0], dir_y[0]);
            else begin
                repeat ((i == 1) ? RC + 1 : RC) @(negedge Clk);
                if (i < 9) drive(dir_x[i], dir_y[i]);
                else if (i == nrand - 1) drive(dir_x[9], dir_y[9]);
                else drive(rnd_val(), rnd_val());
            end
        end

        // Same inputs are captured again; abort that conversion a few cycles into SHIFT.
        repeat (RC) @(negedge Clk);
        drive(xCoord, yCoord);
        repeat (RC + 4) @(negedge Clk);
        check("queue_before_reset", 32'(exp_q.size()), 32'd1);
        check("busy_before_reset", 32'(busy), 32'd1);
        #2;
        Reset = 1'b1;
        exp_q.delete();
        last_e   = '0;
        busy_run = 0;
        #1;
        check("async_rst_xBcd", 32'(xBcd), 32'd0);
        check("async_rst_yBcd", 32'(yBcd), 32'd0);
        check("async_rst_ovf", 32'({xOvf, yOvf}), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("rst_no_update", 32'(updated), 32'd0);
        end
        Reset = 1'b0;
        drive(32'd2468, 32'd13579);
        begin
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 3 * RC) begin
                @(negedge Clk);
                k++;
            end
        end
        check("post_reset_drain", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
